hangman_draw_ctrl: RTL

//  Sequences every pixel write into the Hangman VGA framebuffer port.

---
 rtl/hangman_draw_ctrl_if.sv | 31 +++
 rtl/hangman_draw_ctrl.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/hangman_draw_ctrl_if.sv
// Pixel-drawing bus between Hangman game logic and the framebuffer sequencer:
// game-state / rectangle request inputs, handshake pulses and the pixel stream.
interface hangman_draw_ctrl_if #(
  parameter int COLOUR_W = 3
);
  logic [1:0]          state;
  logic                rect_req;
  logic [8:0]          rect_x;
  logic [7:0]          rect_y;
  logic [8:0]          rect_w;
  logic [7:0]          rect_h;
  logic [COLOUR_W-1:0] rect_colour;
  logic                rect_ack;
  logic                rect_done;
  logic                clear_done;
  logic                busy;
  logic [8:0]          x;
  logic [7:0]          y;
  logic [COLOUR_W-1:0] colour;
  logic                plot;

  modport master (
    output state, rect_req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    input  rect_ack, rect_done, clear_done, busy, x, y, colour, plot
  );

  modport slave (
    input  state, rect_req, rect_x, rect_y, rect_w, rect_h, rect_colour,
    output rect_ack, rect_done, clear_done, busy, x, y, colour, plot
  );
endinterface

// File: rtl/hangman_draw_ctrl.sv
// Framebuffer write sequencer: full-screen clear on game-state change, then
// rectangle fills, one registered pixel per cycle.
module hangman_draw_ctrl #(
  parameter int SCREEN_W     = 320,
  parameter int SCREEN_H     = 240,
  parameter int COLOUR_W     = 3,
  parameter int CLEAR_COLOUR = 0
) (
  input  logic                clk,
  input  logic                reset,
  hangman_draw_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CLEAR, RECT} fsm_t;

  fsm_t                fsm, fsm_nxt;
  logic [1:0]          state_q, state_q_nxt;
  logic                clr_pend, clr_pend_nxt;
  logic [8:0]          x0, x0_nxt, w, w_nxt, cx, cx_nxt;
  logic [7:0]          y0, y0_nxt, h, h_nxt, cy, cy_nxt;
  logic [COLOUR_W-1:0] col, col_nxt;
  logic [8:0]          x_q, x_nxt;
  logic [7:0]          y_q, y_nxt;
  logic [COLOUR_W-1:0] colour_q, colour_nxt;
  logic                plot_q, plot_nxt, busy_q, busy_nxt, ack_q, ack_nxt;
  logic                rdone_q, rdone_nxt, cdone_q, cdone_nxt;
  logic                emit;
  logic [8:0]          ncx;
  logic [7:0]          ncy;
  logic [9:0]          ex;
  logic [8:0]          ey;

  always_comb begin
    fsm_nxt      = fsm;
    state_q_nxt  = state_q;
    clr_pend_nxt = clr_pend;
    x0_nxt       = x0;
    y0_nxt       = y0;
    w_nxt        = w;
    h_nxt        = h;
    col_nxt      = col;
    cx_nxt       = cx;
    cy_nxt       = cy;
    x_nxt        = x_q;
    y_nxt        = y_q;
    colour_nxt   = colour_q;
    plot_nxt     = 1'b0;
    busy_nxt     = 1'b0;
    ack_nxt      = 1'b0;
    rdone_nxt    = 1'b0;
    cdone_nxt    = 1'b0;
    emit         = 1'b0;
    ncx          = '0;
    ncy          = '0;
    ex           = '0;
    ey           = '0;

    case (fsm)
      IDLE: begin
        // A clear is just a walk over a screen-sized rectangle at the origin.
        if (clr_pend) begin
          clr_pend_nxt = 1'b0;
          fsm_nxt      = CLEAR;
          x0_nxt       = '0;
          y0_nxt       = '0;
          w_nxt        = 9'(SCREEN_W);
          h_nxt        = 8'(SCREEN_H);
          col_nxt      = COLOUR_W'(CLEAR_COLOUR);
          emit         = 1'b1;
        end else if (bus.rect_req) begin
          x0_nxt  = bus.rect_x;
          y0_nxt  = bus.rect_y;
          w_nxt   = bus.rect_w;
          h_nxt   = bus.rect_h;
          col_nxt = bus.rect_colour;
          cx_nxt  = '0;
          cy_nxt  = '0;
          ack_nxt = 1'b1;
          fsm_nxt = RECT;
        end
      end
      default: begin
        // busy_q low in RECT marks the ack cycle: no pixel has been emitted yet.
        if (fsm == RECT && !busy_q) begin
          if (w == '0 || h == '0) begin
            rdone_nxt = 1'b1;
            busy_nxt  = 1'b1;
            fsm_nxt   = IDLE;
          end else begin
            emit = 1'b1;
          end
        end else begin
          emit = 1'b1;
          if (cx == w - 9'd1) begin
            ncx = '0;
            ncy = cy + 8'd1;
          end else begin
            ncx = cx + 9'd1;
            ncy = cy;
          end
        end
      end
    endcase

    if (emit) begin
      cx_nxt     = ncx;
      cy_nxt     = ncy;
      ex         = {1'b0, x0_nxt} + {1'b0, ncx};
      ey         = {1'b0, y0_nxt} + {1'b0, ncy};
      x_nxt      = ex[8:0];
      y_nxt      = ey[7:0];
      colour_nxt = col_nxt;
      plot_nxt   = (ex < 10'(SCREEN_W)) && (ey < 9'(SCREEN_H));
      busy_nxt   = 1'b1;
      if (ncx == w_nxt - 9'd1 && ncy == h_nxt - 8'd1) begin
        if (fsm_nxt == CLEAR) cdone_nxt = 1'b1;
        else                  rdone_nxt = 1'b1;
        fsm_nxt = IDLE;
      end
    end

    // Evaluated last so a state change always wins over clearing clr_pend.
    if (bus.state != state_q) begin
      clr_pend_nxt = 1'b1;
      state_q_nxt  = bus.state;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      fsm      <= IDLE;
      state_q  <= bus.state;
      clr_pend <= 1'b1;
      x_q      <= '0;
      y_q      <= '0;
      colour_q <= '0;
      plot_q   <= 1'b0;
      busy_q   <= 1'b0;
      ack_q    <= 1'b0;
      rdone_q  <= 1'b0;
      cdone_q  <= 1'b0;
    end else begin
      fsm      <= fsm_nxt;
      state_q  <= state_q_nxt;
      clr_pend <= clr_pend_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      colour_q <= colour_nxt;
      plot_q   <= plot_nxt;
      busy_q   <= busy_nxt;
      ack_q    <= ack_nxt;
      rdone_q  <= rdone_nxt;
      cdone_q  <= cdone_nxt;
    end
  end

  // Walk operands and counters are always reloaded before use.
  always_ff @(posedge clk) begin
    x0  <= x0_nxt;
    y0  <= y0_nxt;
    w   <= w_nxt;
    h   <= h_nxt;
    col <= col_nxt;
    cx  <= cx_nxt;
    cy  <= cy_nxt;
  end

  assign bus.x          = x_q;
  assign bus.y          = y_q;
  assign bus.colour     = colour_q;
  assign bus.plot       = plot_q;
  assign bus.busy       = busy_q;
  assign bus.rect_ack   = ack_q;
  assign bus.rect_done  = rdone_q;
  assign bus.clear_done = cdone_q;

endmodule
